// File: rtl/oh_debounce.sv
// oh_debounce: per-channel counter debouncer; out follows in after BOUNCE
// stable samples. Ports: clk, reset, in[N], out[N], stable[N]. Macro: OH_DEBOUNCE_SYNC_EN
module oh_debounce #(
  parameter int N      = 1,
  parameter int BOUNCE = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic [N-1:0] stable
);

  localparam int CW = (BOUNCE > 1) ? $clog2(BOUNCE) : 1;
  localparam logic [CW-1:0] CMAX = CW'(BOUNCE - 1);

  logic [N-1:0]         s;
  logic [N-1:0][CW-1:0] cnt;

`ifdef OH_DEBOUNCE_SYNC_EN
  logic [N-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      s    <= '0;
    end else begin
      meta <= in;
      s    <= meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      s <= '0;
    end else begin
      s <= in;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        unique case (1'b1)
          (s[i] == out[i]): begin
            cnt[i] <= '0;
          end
          (s[i] != out[i]) && (cnt[i] == CMAX): begin
            out[i] <= s[i];
            cnt[i] <= '0;
          end
          (s[i] != out[i]) && (cnt[i] != CMAX): begin
            cnt[i] <= cnt[i] + CW'(1);
          end
          default: begin
            cnt[i] <= cnt[i];
          end
        endcase
      end
    end
  end

  always_comb begin
    stable = '0;
    for (int i = 0; i < N; i++) begin
      stable[i] = (cnt[i] == '0);
    end
  end

endmodule

// File: tb/tb_oh_debounce.sv
// tb_oh_debounce: scoreboard bench over three debouncer configs.
// Channels 0-1: BOUNCE=4, channel 2: BOUNCE=1, channel 3: BOUNCE=8.
module tb_oh_debounce;

`ifdef OH_DEBOUNCE_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_all;
  logic [1:0] out4, stb4;
  logic       out1, stb1;
  logic       out8, stb8;

  always #5 clk = ~clk;

  oh_debounce #(.N(2), .BOUNCE(4)) u_d4 (
    .clk(clk), .reset(reset), .in(in_all[1:0]),
    .out(out4), .stable(stb4)
  );
  oh_debounce #(.N(1), .BOUNCE(1)) u_d1 (
    .clk(clk), .reset(reset), .in(in_all[2]),
    .out(out1), .stable(stb1)
  );
  oh_debounce #(.N(1), .BOUNCE(8)) u_d8 (
    .clk(clk), .reset(reset), .in(in_all[3]),
    .out(out8), .stable(stb8)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit done = 0;

  logic [7:0] exp_q[$];

  // Reference: out flips once the last BOUNCE post-reset samples all
  // disagree with it; stable means the newest sample agrees with out.
  logic [3:0] pipe0, pipe1;
  logic [3:0] m_out, m_stb;
  logic [7:0] hist [4];
  int         hlen [4];

  function automatic int bval(input int c);
    if (c < 2) return 4;
    if (c == 2) return 1;
    return 8;
  endfunction

  task automatic model(input logic r, input logic [3:0] x);
    logic [3:0] sv;
    logic [7:0] mask;
    logic [7:0] want;
    if (r) begin
      pipe0 = '0;
      pipe1 = '0;
      m_out = '0;
      for (int c = 0; c < 4; c++) begin
        hist[c] = '0;
        hlen[c] = 0;
      end
    end else begin
      sv = (S == 2) ? pipe1 : pipe0;
      for (int c = 0; c < 4; c++) begin
        hist[c] = {hist[c][6:0], sv[c]};
        if (hlen[c] < 8) hlen[c]++;
        mask = 8'((1 << bval(c)) - 1);
        want = {8{~m_out[c]}};
        if (hlen[c] >= bval(c) && ((hist[c] ^ want) & mask) == 8'h00) begin
          m_out[c] = ~m_out[c];
          hlen[c] = 0;
        end
      end
      pipe1 = pipe0;
      pipe0 = x;
    end
    for (int c = 0; c < 4; c++) begin
      m_stb[c] = !(hlen[c] > 0 && hist[c][0] != m_out[c]);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] x);
    @(negedge clk);
    reset  = r;
    in_all = x;
    model(r, x);
    exp_q.push_back({m_stb, m_out});
  endtask

  initial begin : monitor
    logic [7:0] got, exp;
    while (!done) begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {stb8, stb1, stb4, out8, out1, out4};
        compared++;
        if (got !== exp) begin
          mismatched++;
          $display("FAIL cycle %0d out_stable: got %b required %b",
                   cyc, got, exp);
        end
      end
    end
  end

  initial begin : driver
    logic [3:0] x;
    reset  = 1'b1;
    in_all = 4'b1111;
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1111);
    for (int i = 0; i < 14; i++) step(1'b0, 4'b1111);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0000);
    for (int i = 0; i < 12; i++) step(1'b0, 4'b1111);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b1111);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b1111);
    step(1'b0, 4'b0000);
    for (int i = 0; i < 14; i++) step(1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) step(1'b0, 4'b1111);
    step(1'b1, 4'b1111);
    for (int i = 0; i < 14; i++) step(1'b0, 4'b1111);
    x = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 5) == 0) x[c] = ~x[c];
      end
      step($urandom_range(0, 149) == 0, x);
    end
    for (int i = 0; i < 12; i++) step(1'b0, x);
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d left required 0", exp_q.size());
    end
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/oh_debounce.md
Name: oh_debounce

Overview:
- Per-channel counter-based debouncer for noisy level inputs (buttons, external strobes, slow status pins).
- Produces a clean, glitch-free level suitable as the edge input of the downstream rising-edge-to-pulse stage.
- Each of N channels is independent. Each has an input-sampling stage and a stability counter; the output changes only after the input has held a new value for BOUNCE consecutive cycles.

Parameters:
- N, 1, number of independent channels.
- BOUNCE, 16, consecutive cycles the sampled input must differ from the output before the output updates; legal range 1..65535.
- CW, derived (localparam), counter width = max(1, $clog2(BOUNCE)); not user-settable.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  synchronous active-high reset.
- in  input  N  raw, possibly bouncing level inputs.
- out  output  N  debounced level; registered.
- stable  output  N  high when the channel counter is zero, i.e. no pending change; registered/decoded from registered state only.

Behaviour:
- Reset (reset=1 at clk edge): all sampling flops=0, all counters=0, out=0, stable=all ones.
  - Reset wins over all other activity.
  - Reset mid-count discards the pending change.
- Sampling: s[i] is in[i] after S register stages.
  - S=2 with OH_DEBOUNCE_SYNC_EN defined; S=1 without it.
  - No combinational path from in to out or stable.
- Per channel, each clk edge when reset=0:
  - s==out: cnt<=0.
  - s!=out and cnt==BOUNCE-1: out<=s, cnt<=0.
  - s!=out and cnt<BOUNCE-1: cnt<=cnt+1.
- Equivalent two-state view per channel:
  - IDLE (cnt==0, s==out).
  - COUNT (s!=out).
  - COUNT returns to IDLE on a glitch (s reverts) or on commit (cnt reaches BOUNCE-1).
- Latency: in changes before edge 1 and then holds. out reflects the new value after edge S+BOUNCE. Examples:
  - BOUNCE=4, S=2: after edge 6.
  - BOUNCE=1, S=1: after edge 2.
- Glitch rejection: any return of s to the current out value before commit clears cnt. A later change restarts the full BOUNCE count.
- Counter never exceeds BOUNCE-1; no wrap-around possible.
- out changes at most once per BOUNCE cycles per channel. A commit cannot be followed by another toggle earlier than BOUNCE cycles later.
- stable = (cnt==0). stable is low for exactly BOUNCE-1 cycles preceding a commit; for BOUNCE=1, stable is always 1.
- Channels share no state; simultaneous changes on several channels are processed independently in the same cycles.

Optional Feature:
- OH_DEBOUNCE_SYNC_EN defined:
  - Two-flop synchronizer in front of the counter (S=2); safe for asynchronous in.
  - Synchronizer flops are synchronously reset to 0.
- Not defined:
  - Single input register (S=1); in must already be synchronous to clk.
  - Total latency one cycle less.
- Counter/commit behaviour is identical in both builds.

Test Plan:
- Reset: BOUNCE=4, N=2, in=2'b11 held, reset=1 for 3 edges -> out=00, stable=11 during reset. After release, out=11 at edge S+4, with stable low for the preceding 3 cycles.
- Clean rise: BOUNCE=4, SYNC_EN defined, in 0->1 before edge 1, held -> out=0 through edge 5, out=1 after edge 6, stable low after edges 3..5.
- Glitch reject: BOUNCE=4, in=1 for 3 cycles then 0 -> out stays 0, cnt back to 0, stable=1. No output pulse ever visible.
- Bounce then settle: in toggles 1,0,1,0,1 each cycle, then holds 1 -> out=1 exactly BOUNCE cycles after the final stable sample, single transition only.
- BOUNCE=1 without SYNC_EN: in 0->1 before edge 1 -> out=1 after edge 2, stable always 1. in 1->0 -> out=0 two edges later.
- Reset mid-count: BOUNCE=8, in=1 held, reset asserted at cycle 5 for 1 edge -> out=0, counter cleared. After release, commit occurs a full S+8 edges later.
